// File: rtl/dtw_pkg.sv
// Shared constants, state encoding and the training-code decoder for the
// DTW scheduler slice.
package dtw_pkg;

  localparam int SCORE_W = 27;
  localparam int N_TEMPL = 9;

  localparam logic [3:0] NOISE_SLOT = 4'd8;

  // Command word codes. Word slots 0..7 map onto 4'b0100..4'b1011.
  localparam logic [3:0] CMD_NONE      = 4'b0000;
  localparam logic [3:0] CMD_NONE_WORD = 4'b0100;
  localparam logic [3:0] CMD_RED       = 4'b0101;
  localparam logic [3:0] CMD_BLACK     = 4'b0110;
  localparam logic [3:0] CMD_BLUE      = 4'b0111;
  localparam logic [3:0] CMD_LEFT      = 4'b1000;
  localparam logic [3:0] CMD_RIGHT     = 4'b1001;
  localparam logic [3:0] CMD_GO        = 4'b1010;
  localparam logic [3:0] CMD_STOP      = 4'b1011;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    LAUNCH       = 3'd1,
    WAIT         = 3'd2,
    DECIDE       = 3'd3,
    TRAIN_LAUNCH = 3'd4,
    TRAIN_WAIT   = 3'd5
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] slot;
  } train_map_t;

  // Word code -> template slot. 0000 trains the noise slot, word codes
  // 0100..1011 train slots 0..7, everything else is rejected.
  function automatic train_map_t train_slot(input logic [3:0] code);
    train_map_t m;
    m.valid = 1'b0;
    m.slot  = 4'd0;
    if (code == CMD_NONE) begin
      m.valid = 1'b1;
      m.slot  = NOISE_SLOT;
    end else if (code >= CMD_NONE_WORD && code <= CMD_STOP) begin
      m.valid = 1'b1;
      m.slot  = code - 4'd4;
    end
    return m;
  endfunction

endpackage

// File: rtl/dtw_min_tracker.sv
// Running argmin over the word-slot scores of one utterance. A strictly-less
// update means equal scores keep the earlier (lower) slot index.
module dtw_min_tracker #(
  parameter int SCORE_W = 27
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               update,
  input  logic [SCORE_W-1:0] score,
  input  logic [3:0]         idx,
  output logic [SCORE_W-1:0] min_score,
  output logic [3:0]         min_idx
);

  // Clear to the worst possible score, then keep the smallest seen so far.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      min_score <= '1;
      min_idx   <= 4'd0;
    end else if (update && (score < min_score)) begin
      min_score <= score;
      min_idx   <= idx;
    end
  end

endmodule

// File: rtl/dtw_scheduler.sv
// Shares one DTW engine across the nine template slots: scores an utterance
// against slots 0..8 in turn and issues the best word if it beats noise, or
// routes a training utterance to a single slot.
//
// Engine handshake: dtw_start is a one-cycle request carrying dtw_train and
// dtw_slot; there is no ready/backpressure. dtw_done is a one-cycle response
// with dtw_score valid in the same cycle, and it is only accepted in WAIT or
// TRAIN_WAIT -- a done seen in any other state is ignored.
module dtw_scheduler #(
  parameter int SCORE_W = dtw_pkg::SCORE_W,
  parameter int TIMEOUT = 1048576
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               utter_ready,
  input  logic               training_enable,
  input  logic [3:0]         training_select,
  output logic               dtw_start,
  output logic               dtw_train,
  output logic [3:0]         dtw_slot,
  input  logic               dtw_done,
  input  logic [SCORE_W-1:0] dtw_score,
  output logic               busy,
  output logic               command_valid,
  output logic [3:0]         command,
  output logic [SCORE_W-1:0] best_score,
  output logic               overrun
);

  import dtw_pkg::*;

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  state_t             state;
  logic [3:0]         slot;
  logic [TW-1:0]      timer;
  logic [SCORE_W-1:0] noise_score;
  logic [SCORE_W-1:0] noise_next;
  logic [SCORE_W-1:0] min_score;
  logic [3:0]         min_idx;

  logic               slot_finish;
  logic [SCORE_W-1:0] slot_score;
  logic               start_recog;
  logic               word_update;
  logic               noise_finish;
  train_map_t         train_map;

  // A slot finishes on done or when the wait budget runs out; a timed-out
  // slot scores as all-ones so it can never win.
  always_comb begin
    slot_finish  = dtw_done || (timer == TIMER_LAST);
    slot_score   = dtw_done ? dtw_score : '1;
    start_recog  = (state == IDLE) && utter_ready && !training_enable;
    word_update  = (state == WAIT) && slot_finish && (slot != NOISE_SLOT);
    noise_finish = (state == WAIT) && slot_finish && (slot == NOISE_SLOT);
    train_map    = train_slot(training_select);
    noise_next   = noise_score;
    if (noise_finish) noise_next = slot_score;
  end

  dtw_min_tracker #(.SCORE_W(SCORE_W)) u_min (
    .clock     (clock),
    .reset     (reset),
    .clear     (start_recog),
    .update    (word_update),
    .score     (slot_score),
    .idx       (slot),
    .min_score (min_score),
    .min_idx   (min_idx)
  );

  // Sequencer: walks the slots, makes the decision, and drives every output
  // from a register so consumers see clean one-cycle pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      slot          <= 4'd0;
      timer         <= '0;
      noise_score   <= '1;
      dtw_start     <= 1'b0;
      dtw_train     <= 1'b0;
      dtw_slot      <= 4'd0;
      busy          <= 1'b0;
      command_valid <= 1'b0;
      command       <= CMD_NONE;
      best_score    <= '0;
      overrun       <= 1'b0;
    end else begin
      dtw_start     <= 1'b0;
      dtw_train     <= 1'b0;
      command_valid <= 1'b0;
      command       <= CMD_NONE;
      overrun       <= utter_ready && (state != IDLE);
      noise_score   <= noise_next;

      case (state)
        IDLE: begin
          if (utter_ready && !training_enable) begin
            state     <= LAUNCH;
            slot      <= 4'd0;
            dtw_slot  <= 4'd0;
            dtw_start <= 1'b1;
            busy      <= 1'b1;
          end else if (utter_ready && train_map.valid) begin
            state     <= TRAIN_LAUNCH;
            dtw_slot  <= train_map.slot;
            dtw_start <= 1'b1;
            dtw_train <= 1'b1;
            busy      <= 1'b1;
          end
        end

        LAUNCH: begin
          state <= WAIT;
          timer <= '0;
        end

        WAIT: begin
          if (slot_finish) begin
            if (slot == NOISE_SLOT) begin
              state         <= DECIDE;
              command_valid <= 1'b1;
              command       <= (min_score < noise_next) ? (CMD_NONE_WORD + min_idx) : CMD_NONE;
              best_score    <= min_score;
            end else begin
              state     <= LAUNCH;
              slot      <= slot + 4'd1;
              dtw_slot  <= slot + 4'd1;
              dtw_start <= 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        DECIDE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        TRAIN_LAUNCH: begin
          state <= TRAIN_WAIT;
          timer <= '0;
        end

        TRAIN_WAIT: begin
          if (slot_finish) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dtw_scheduler.sv
// Directed bench for dtw_scheduler: a scripted engine answers each dtw_start,
// expected decisions are queued on stimulus and popped on command_valid.
module tb_dtw_scheduler;

  import dtw_pkg::*;

  localparam int SW = 27;
  localparam int TO = 16;
  localparam int L  = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          utter_ready;
  logic          training_enable;
  logic [3:0]    training_select;
  logic          dtw_start;
  logic          dtw_train;
  logic [3:0]    dtw_slot;
  logic          dtw_done;
  logic [SW-1:0] dtw_score;
  logic          busy;
  logic          command_valid;
  logic [3:0]    command;
  logic [SW-1:0] best_score;
  logic          overrun;

  logic [30:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_cnt = 0;
  int cv_cnt    = 0;
  int base_s;
  int base_c;

  int unsigned sc_rec   [9] = '{50, 40, 30, 20, 10, 60, 70, 80, 100};
  int unsigned sc_noise [9] = '{200, 200, 200, 200, 200, 200, 200, 200, 150};
  int unsigned sc_tie   [9] = '{99, 99, 5, 99, 99, 5, 99, 99, 99};
  int unsigned sc_to    [9] = '{50, 40, 30, 1, 10, 60, 70, 80, 100};

  // clock / reset
  always #5 clock = ~clock;

  dtw_scheduler #(.SCORE_W(SW), .TIMEOUT(TO)) dut (
    .clock           (clock),
    .reset           (reset),
    .utter_ready     (utter_ready),
    .training_enable (training_enable),
    .training_select (training_select),
    .dtw_start       (dtw_start),
    .dtw_train       (dtw_train),
    .dtw_slot        (dtw_slot),
    .dtw_done        (dtw_done),
    .dtw_score       (dtw_score),
    .busy            (busy),
    .command_valid   (command_valid),
    .command         (command),
    .best_score      (best_score),
    .overrun         (overrun)
  );

  // pulse counters sampled on the active edge (pre-update values)
  always @(posedge clock) begin
    if (dtw_start === 1'b1) start_cnt++;
    if (command_valid === 1'b1) cv_cnt++;
  end

  task automatic tick();
    @(negedge clock);
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dtw_start"}, 32'(dtw_start), 0);
    check({tag, "_dtw_train"}, 32'(dtw_train), 0);
    check({tag, "_dtw_slot"}, 32'(dtw_slot), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_command_valid"}, 32'(command_valid), 0);
    check({tag, "_command"}, 32'(command), 0);
    check({tag, "_best_score"}, 32'(best_score), 0);
    check({tag, "_overrun"}, 32'(overrun), 0);
  endtask

  // Drive one recognition. hold: slot whose done is withheld (-1 none);
  // abort: slot in whose WAIT reset is applied (-1 none).
  task automatic run_recog(input string tag, input int unsigned sc [9], input int hold,
                           input int abort, input logic [3:0] e_cmd, input logic [SW-1:0] e_best);
    logic [30:0] e;
    if (abort < 0) exp_q.push_back({e_cmd, e_best});
    utter_ready = 1'b1;
    cyc = 0;
    tick();
    utter_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      for (int n = 0; n < 200 && dtw_start !== 1'b1; n++) tick();
      check({tag, "_start"}, 32'(dtw_start), 1);
      if (hold < 0) check({tag, "_start_cyc"}, cyc, 1 + k * (L + 1));
      check({tag, "_slot"}, 32'(dtw_slot), k);
      check({tag, "_train"}, 32'(dtw_train), 0);
      if (k == abort) begin
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_outputs({tag, "_after_reset"});
        base_s = start_cnt;
        base_c = cv_cnt;
        dtw_done = 1'b1;
        dtw_score = SW'(1);
        tick();
        dtw_done = 1'b0;
        dtw_score = '0;
        repeat (40) tick();
        check({tag, "_stray_starts"}, start_cnt - base_s, 0);
        check({tag, "_stray_cv"}, cv_cnt - base_c, 0);
        check({tag, "_stray_busy"}, 32'(busy), 0);
        return;
      end
      if (k == hold) begin
        utter_ready = 1'b1;
        tick();
        utter_ready = 1'b0;
        check({tag, "_overrun_pulse"}, 32'(overrun), 1);
        tick();
        check({tag, "_overrun_clear"}, 32'(overrun), 0);
      end else begin
        repeat (L) tick();
        check({tag, "_slot_stable"}, 32'(dtw_slot), k);
        dtw_done = 1'b1;
        dtw_score = sc[k][SW-1:0];
        tick();
        dtw_done = 1'b0;
        dtw_score = '0;
      end
    end
    for (int n = 0; n < 200 && command_valid !== 1'b1; n++) tick();
    check({tag, "_cv"}, 32'(command_valid), 1);
    if (hold < 0) check({tag, "_cv_cyc"}, cyc, 9 * (L + 1) + 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_command"}, 32'(command), 32'(e[30:27]));
      check({tag, "_best"}, 32'(best_score), 32'(e[26:0]));
    end
    tick();
    check({tag, "_cv_low"}, 32'(command_valid), 0);
    check({tag, "_command_low"}, 32'(command), 0);
    check({tag, "_busy_low"}, 32'(busy), 0);
    check({tag, "_best_held"}, 32'(best_score), 32'(e_best));
  endtask

  initial begin
    reset = 1'b1;
    utter_ready = 1'b0;
    training_enable = 1'b0;
    training_select = 4'd0;
    dtw_done = 1'b0;
    dtw_score = '0;
    repeat (3) tick();
    check_reset_outputs("reset");
    reset = 1'b0;
    tick();

    // recognition with latency checks
    run_recog("rec", sc_rec, -1, -1, 4'b1000, SW'(10));
    tick();
    // noise beats every word
    run_recog("noise", sc_noise, -1, -1, CMD_NONE, SW'(200));
    tick();
    // tie keeps the lower slot
    run_recog("tie", sc_tie, -1, -1, 4'b0110, SW'(5));
    tick();

    // training to slot 6; mode dropped right after the request
    base_s = start_cnt;
    base_c = cv_cnt;
    training_enable = 1'b1;
    training_select = 4'b1010;
    utter_ready = 1'b1;
    cyc = 0;
    tick();
    utter_ready = 1'b0;
    training_enable = 1'b0;
    check("train_start", 32'(dtw_start), 1);
    check("train_flag", 32'(dtw_train), 1);
    check("train_slot", 32'(dtw_slot), 6);
    check("train_busy", 32'(busy), 1);
    repeat (L) tick();
    check("train_busy_wait", 32'(busy), 1);
    dtw_done = 1'b1;
    tick();
    dtw_done = 1'b0;
    check("train_idle_cyc", 32'(busy), 0);
    repeat (5) tick();
    check("train_one_start", start_cnt - base_s, 1);
    check("train_no_cv", cv_cnt - base_c, 0);

    // training to the noise slot
    training_enable = 1'b1;
    training_select = 4'b0000;
    utter_ready = 1'b1;
    tick();
    utter_ready = 1'b0;
    training_enable = 1'b0;
    check("train_noise_slot", 32'(dtw_slot), 8);
    check("train_noise_flag", 32'(dtw_train), 1);
    repeat (L) tick();
    dtw_done = 1'b1;
    tick();
    dtw_done = 1'b0;
    tick();

    // invalid training code is ignored
    base_s = start_cnt;
    training_enable = 1'b1;
    training_select = 4'b0011;
    utter_ready = 1'b1;
    tick();
    utter_ready = 1'b0;
    training_enable = 1'b0;
    repeat (6) tick();
    check("invalid_no_start", start_cnt - base_s, 0);
    check("invalid_idle", 32'(busy), 0);

    // slot 3 times out (its would-be winning score is never delivered)
    run_recog("timeout", sc_to, 3, -1, 4'b1000, SW'(10));
    tick();

    // reset in WAIT of slot 4 plus a stray done, then a clean run
    run_recog("abort", sc_rec, -1, 4, CMD_NONE, '0);
    run_recog("after_abort", sc_tie, -1, -1, 4'b0110, SW'(5));

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
